// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU package for the sequential multiplier.
// Holds the FSM state encoding, the default operand width, the iteration
// counter width and the fixed start-to-done latency.
package alu_mul_seq_pkg;

    localparam int ALU_WIDTH   = 16;
    localparam int ALU_CNT_W   = 5;
    localparam int MUL_LATENCY = ALU_WIDTH + 1;

    // Code 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Start-to-done latency in cycles for a given operand width.
    function automatic int mul_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result bundle between the ALU control and the multiplier.
//   start        : request pulse (master -> slave)
//   a, b         : unsigned operands (master -> slave)
//   res_lo/hi    : low/high product words (slave -> master)
//   busy, done   : status (slave -> master)
interface alu_mul_seq_if
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  res_lo, res_hi, busy, done
    );

    modport slave (
        input  start, a, b,
        output res_lo, res_hi, busy, done
    );
endinterface

// File: rtl/alu_mul_dp.sv
// Shift-and-add multiplier datapath.
// Holds the multiplicand, multiplier and the 2*WIDTH-bit accumulator.
//   clk, rst      : clock, synchronous active-high reset (clears all regs)
//   load          : capture a/b and clear the accumulator
//   step          : one conditional-add + right-shift iteration
//   a, b          : operands
//   acc_hi/acc_lo : current accumulator; holds the product after WIDTH steps
module alu_mul_dp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // The sum is one bit wider than acc_hi so the carry-out survives; it
    // becomes the MSB of acc_hi after the shift.
    assign addend = mplier_q[0] ? mcand_q : '0;
    assign sum    = {1'b0, acc_hi_q} + {1'b0, addend};

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else if (load) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else if (step) begin
            // {carry, acc_hi, acc_lo, mplier} >> 1
            acc_hi_q <= sum[WIDTH:1];
            acc_lo_q <= {sum[0], acc_lo_q[WIDTH-1:1]};
            mplier_q <= {acc_lo_q[0], mplier_q[WIDTH-1:1]};
        end
    end

    assign acc_hi = acc_hi_q;
    assign acc_lo = acc_lo_q;
endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier (ALU unit).
// One start pulse launches WIDTH iterations; done pulses once with the
// 2*WIDTH-bit product on res_hi/res_lo, which then hold until the next result.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of alu_mul_seq_if (start, a, b, res_lo, res_hi,
//              busy, done)
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = ALU_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    alu_mul_seq_if.slave   bus
);
    if ((2 ** CNT_W) <= WIDTH) begin : g_cnt_check
        $error("CNT_W too small for WIDTH");
    end

    mul_state_t       state_q;
    mul_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] res_lo_q;
    logic [WIDTH-1:0] res_hi_q;
    logic             done_q;

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // done is registered alongside the result so both appear on the same
    // cycle, one edge after the DONE state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_DONE);
            if (load) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_DONE) begin
                res_lo_q <= acc_lo;
                res_hi_q <= acc_hi;
            end
        end
    end

    alu_mul_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .a      (bus.a),
        .b      (bus.b),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    assign bus.res_lo = res_lo_q;
    assign bus.res_hi = res_hi_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned shift-and-add multiplier for the processor ALU.
- It is the additive counterpart to the registered subtract unit: the result is built by repeated conditional addition instead of subtraction.
- The ALU control issues one operation with a start pulse, waits for done, then reads a 2*WIDTH-bit product split into hi and lo words.
- The block sits beside the other ALU units and shares their clk/rst.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, unsigned, captured when start is accepted
- b  input  WIDTH  multiplier, unsigned, captured when start is accepted
- res_lo  output  WIDTH  product bits [WIDTH-1:0], registered
- res_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH], registered
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid on that cycle and held afterwards

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; res_lo=0, res_hi=0, busy=0, done=0; counter=0; internal operand registers=0.
- rst overrides everything, including mid-operation. The partial product is discarded and the outputs read 0 on the next cycle.
- State IDLE:
  - busy=0, done=0.
  - If start=1: capture mcand<=a, mplier<=b, acc<=0, cnt<=0; go to RUN.
- State RUN (exactly WIDTH cycles):
  - Each cycle: if mplier[0]=1, then acc_hi <= acc_hi + mcand, with the carry-out kept as a (WIDTH+1)-bit sum.
  - Then shift {carry, acc_hi, acc_lo, mplier} right by one; the carry enters the MSB of acc_hi.
  - cnt increments each cycle. When cnt==WIDTH-1, go to DONE.
- State DONE (one cycle):
  - res_hi/res_lo <= acc; done=1, busy=1; next state IDLE.
  - res_lo/res_hi are registered outputs that update only here.
- Latency: start sampled at edge N; done=1 during the cycle after edge N+WIDTH+1 (17 cycles for WIDTH=16); the result is visible together with done.
- Outputs hold the last product until the next DONE or reset. They do not change while a new operation is RUN-ing.
- start while busy=1 is ignored: no queueing, no restart.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE, using a/b sampled at that edge.
- a or b changing during RUN has no effect.
- Arithmetic is unsigned modulo 2**(2*WIDTH). The full product always fits, so there is no overflow flag.
- Zero operand: all WIDTH iterations still run; latency is fixed and data-independent.
- Max operands (all ones): the adder carry-out must be kept. Dropping it is a defect.

Decomposition:
- Shared ALU package holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; code 2'd3 returns to IDLE.
  - default WIDTH=16.
  - MUL_LATENCY = WIDTH+1.
- One sub-module is natural: alu_mul_dp (datapath). It holds the acc/mplier/mcand registers, the WIDTH+1-bit adder and the shifter, and is controlled by load/step signals.
- The FSM and counter stay in alu_mul_seq.

Test Plan:
- Reset: rst=1 for 2 cycles mid-RUN of 0x1234*0x0010 -> res_lo=res_hi=0, busy=0, done=0 the cycle after; the next start works normally.
- Basic: a=0x0005, b=0x0003, start pulse -> done exactly 17 cycles later with res_hi=0x0000, res_lo=0x000F; busy high 17 cycles.
- Max carry: a=0xFFFF, b=0xFFFF -> res_hi=0xFFFE, res_lo=0x0001.
- Zero/identity:
  - a=0x0000, b=0xABCD -> product 0, still 17-cycle latency.
  - a=0x1234, b=0x0001 -> res_hi=0x0000, res_lo=0x1234.
- Busy protection: start a=0x0100, b=0x0100, then pulse start with a=0x0002, b=0x0002 and change a/b during RUN -> result res_hi=0x0001, res_lo=0x0000; second start ignored, no second done.
- Back-to-back: start held high with a=0x0003, b=0x0007 then a=0x00FF, b=0x0002 -> done pulses 18 cycles apart, results 0x00000015 then 0x000001FE; outputs hold between pulses.
